// File: rtl/stage2_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// stage2_maxpool_2x2
//
// 2x2 / stride-2 max-pooling of the stage-2 convolution feature map. Pixels
// arrive in raster order, one per valid beat, with all CH channels in
// parallel. The block produces an (IN_Y/2)x(IN_X/2) raster-ordered map per
// frame. It stores only half a row of partial maxima plus one horizontal pair
// register, so no full-frame buffer is needed.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous, active-low reset
//   i_in_valid   input pixel strobe, one pixel per asserted cycle
//   i_in_fmap    input pixel, channel k at bits [k*DW +: DW] (unsigned)
//   o_ot_valid   single-cycle strobe per pooled pixel
//   o_ot_fmap    pooled pixel, same packing, held until the next output
//   o_frame_done pulse coincident with the last pooled output of a frame
// -----------------------------------------------------------------------------
module stage2_maxpool_2x2 #(
  parameter int CH   = 3,
  parameter int DW   = 32,
  parameter int IN_X = 8,
  parameter int IN_Y = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_in_valid,
  input  logic [CH*DW-1:0] i_in_fmap,
  output logic             o_ot_valid,
  output logic [CH*DW-1:0] o_ot_fmap,
  output logic             o_frame_done
);

  localparam int W  = CH * DW;
  localparam int HX = IN_X / 2;
  localparam int CW = (IN_X > 1) ? $clog2(IN_X) : 1;
  localparam int RW = (IN_Y > 1) ? $clog2(IN_Y) : 1;
  localparam int SW = (HX > 1) ? $clog2(HX) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_X - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_Y - 1);

  // Geometry sanity: the pooling window walk assumes even, non-trivial sizes.
  if ((IN_X < 2) || (IN_X % 2 != 0)) begin : g_bad_in_x
    $error("stage2_maxpool_2x2: IN_X must be even and >= 2");
  end
  if ((IN_Y < 2) || (IN_Y % 2 != 0)) begin : g_bad_in_y
    $error("stage2_maxpool_2x2: IN_Y must be even and >= 2");
  end

  // Unsigned per-channel maximum; on a tie both operands are equal anyway.
  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Position of the incoming pixel inside the frame.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Horizontal pair register and half-row buffer of top-pair maxima.
  logic [W-1:0]  pair_p0;
  logic [W-1:0]  rowbuf_p0 [HX];

  // Combinational maxima against the incoming pixel.
  logic [W-1:0]  hmax;   // max(pair, in)
  logic [W-1:0]  vmax;   // max(rowbuf[col>>1], in)
  logic [SW-1:0] slot;   // row-buffer entry of the current column pair
  logic          last_beat;

  assign slot      = SW'(col >> 1);
  assign last_beat = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    hmax = '0;
    vmax = '0;
    for (int k = 0; k < CH; k++) begin
      hmax[k*DW +: DW] = umax(pair_p0[k*DW +: DW], i_in_fmap[k*DW +: DW]);
      vmax[k*DW +: DW] = umax(rowbuf_p0[slot][k*DW +: DW],
                              i_in_fmap[k*DW +: DW]);
    end
  end

  // ---- stage p0: position counters, pair register, row buffer ----
  // ---- stage p1: pooled output register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col          <= '0;
      row          <= '0;
      pair_p0      <= '0;
      for (int i = 0; i < HX; i++) begin
        rowbuf_p0[i] <= '0;
      end
      o_ot_valid   <= 1'b0;
      o_ot_fmap    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_in_valid) begin
        // Frame boundaries are handled purely by counter wrap, so frames
        // can follow each other with no gap.
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end

        // Even rows always write every row-buffer entry before the odd row
        // reads it, so stale data from an earlier frame is never used.
        unique case ({row[0], col[0]})
          2'b00: pair_p0         <= i_in_fmap;
          2'b01: rowbuf_p0[slot] <= hmax;
          2'b10: pair_p0         <= vmax;
          2'b11: begin
            o_ot_fmap    <= hmax;
            o_ot_valid   <= 1'b1;
            o_frame_done <= last_beat;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage2_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// tb_stage2_maxpool_2x2
//
// Self-checking bench for stage2_maxpool_2x2. Frames are described as pixel
// arrays; the expected pooled map is the maximum over each 2x2 window of that
// array. Every observed output records which input beat preceded it, so the
// one-cycle latency and the absence of spurious strobes are checked as well.
// -----------------------------------------------------------------------------
module tb_stage2_maxpool_2x2;

  localparam int CH   = 3;
  localparam int DW   = 32;
  localparam int IN_X = 8;
  localparam int IN_Y = 8;
  localparam int W    = CH * DW;
  localparam int NPIX = IN_X * IN_Y;
  localparam int OX   = IN_X / 2;
  localparam int NOUT = (IN_X / 2) * (IN_Y / 2);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_fmap = '0;
  logic         ot_valid;
  logic [W-1:0] ot_fmap;
  logic         frame_done;

  int errors = 0;
  int checks = 0;

  // Current frame contents and observed outputs.
  logic [W-1:0] pix [NPIX];
  logic [W-1:0] obs_val [$];
  logic         obs_done [$];
  int           obs_beat [$];
  logic         obs_adj [$];
  int           last_beat = -1;
  logic         last_valid = 1'b0;

  stage2_maxpool_2x2 #(
    .CH(CH), .DW(DW), .IN_X(IN_X), .IN_Y(IN_Y)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_in_valid   (in_valid),
    .i_in_fmap    (in_fmap),
    .o_ot_valid   (ot_valid),
    .o_ot_fmap    (ot_fmap),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference: each pooled pixel is the per-channel maximum of its window.
  function automatic logic [W-1:0] model_out(input int wr, input int wc);
    logic [W-1:0]  r;
    logic [DW-1:0] m;
    logic [DW-1:0] v;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      m = '0;
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) begin
          v = pix[(2*wr + a)*IN_X + 2*wc + b][k*DW +: DW];
          if (v > m) m = v;
        end
      r[k*DW +: DW] = m;
    end
    return r;
  endfunction

  function automatic int br_beat(input int j);
    return (2*(j / OX) + 1)*IN_X + 2*(j % OX) + 1;
  endfunction

  task automatic set_ramp(input int off);
    for (int i = 0; i < NPIX; i++)
      for (int k = 0; k < CH; k++)
        pix[i][k*DW +: DW] = DW'(i + off);
  endtask

  task automatic clear_obs();
    obs_val.delete();
    obs_done.delete();
    obs_beat.delete();
    obs_adj.delete();
  endtask

  // Advance one clock and record any output strobe with its context.
  task automatic step();
    @(posedge clk);
    #1;
    if (ot_valid) begin
      obs_val.push_back(ot_fmap);
      obs_done.push_back(frame_done);
      obs_beat.push_back(last_beat);
      obs_adj.push_back(last_valid);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b0;
      last_valid = 1'b0;
      step();
    end
  endtask

  // Stream beats [0, nbeats) of pix, inserting random idle cycles.
  task automatic run_beats(input int nbeats, input int gap_pct);
    for (int i = 0; i < nbeats; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid   = 1'b0;
        last_valid = 1'b0;
        step();
      end
      in_valid   = 1'b1;
      in_fmap    = pix[i];
      last_beat  = i;
      last_valid = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (ot_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", ot_valid);
    end
    checks++;
    if (ot_fmap !== '0) begin
      errors++; $display("FAIL reset_fmap got %h want 0", ot_fmap);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", frame_done);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_ramp();
    logic [W-1:0] exp;
    int           ndone;
    set_ramp(0);
    clear_obs();
    run_beats(NPIX, 0);
    idle(3);
    checks++;
    if (obs_val.size() != NOUT) begin
      errors++; $display("FAIL ramp_count got %0d want %0d", obs_val.size(), NOUT);
    end
    ndone = 0;
    for (int j = 0; j < NOUT && j < obs_val.size(); j++) begin
      exp = model_out(j / OX, j % OX);
      if (obs_done[j]) ndone++;
      checks++;
      if (obs_val[j] !== exp || obs_done[j] !== (j == NOUT-1) ||
          obs_beat[j] != br_beat(j) || obs_adj[j] !== 1'b1) begin
        errors++;
        $display("FAIL ramp_out%0d got %h done=%b beat=%0d adj=%b want %h done=%b beat=%0d adj=1",
                 j, obs_val[j], obs_done[j], obs_beat[j], obs_adj[j],
                 exp, (j == NOUT-1), br_beat(j));
      end
      // Independent closed form for the ramp: 9, 11, 13, 15, 25, ...
      checks++;
      if (obs_val[j][DW-1:0] !== DW'(16*(j / OX) + 2*(j % OX) + 9)) begin
        errors++;
        $display("FAIL ramp_const%0d got %0d want %0d", j, obs_val[j][DW-1:0],
                 16*(j / OX) + 2*(j % OX) + 9);
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL ramp_done_pulses got %0d want 1", ndone);
    end
  endtask

  task automatic test_channels();
    logic [W-1:0] exp;
    for (int i = 0; i < NPIX; i++) begin
      pix[i][0*DW +: DW] = DW'(i);
      pix[i][1*DW +: DW] = DW'(100 - i);
      pix[i][2*DW +: DW] = '0;
    end
    clear_obs();
    run_beats(NPIX, 0);
    idle(2);
    checks++;
    if (obs_val.size() != NOUT) begin
      errors++; $display("FAIL chan_count got %0d want %0d", obs_val.size(), NOUT);
    end
    for (int j = 0; j < NOUT && j < obs_val.size(); j++) begin
      exp = model_out(j / OX, j % OX);
      checks++;
      if (obs_val[j] !== exp ||
          obs_val[j][1*DW +: DW] !== DW'(100 - (16*(j / OX) + 2*(j % OX))) ||
          obs_val[j][2*DW +: DW] !== '0) begin
        errors++;
        $display("FAIL chan_out%0d got %h want %h", j, obs_val[j], exp);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] win [4];
    logic [W-1:0]  exp;
    win[0] = 32'h0000_0001;
    win[1] = 32'hFFFF_FFFF;
    win[2] = 32'h8000_0000;
    win[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < NPIX; i++) pix[i] = '0;
    // Rotate the window per channel so the maximum sits in a different corner.
    for (int k = 0; k < CH; k++) begin
      pix[0][k*DW +: DW]        = win[(0 + k) % 4];
      pix[1][k*DW +: DW]        = win[(1 + k) % 4];
      pix[IN_X][k*DW +: DW]     = win[(2 + k) % 4];
      pix[IN_X + 1][k*DW +: DW] = win[(3 + k) % 4];
    end
    clear_obs();
    run_beats(NPIX, 0);
    idle(2);
    checks++;
    if (obs_val.size() != NOUT) begin
      errors++; $display("FAIL uns_count got %0d want %0d", obs_val.size(), NOUT);
    end else begin
      exp = {CH{32'hFFFF_FFFF}};
      checks++;
      if (obs_val[0] !== exp) begin
        errors++; $display("FAIL uns_window got %h want %h", obs_val[0], exp);
      end
      checks++;
      if (obs_val[1] !== '0) begin
        errors++; $display("FAIL uns_zero got %h want 0", obs_val[1]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] exp;
    for (int rep = 0; rep < 2; rep++) begin
      if (rep == 0) set_ramp(0);
      else
        for (int i = 0; i < NPIX; i++)
          for (int k = 0; k < CH; k++)
            pix[i][k*DW +: DW] = $urandom();
      clear_obs();
      run_beats(NPIX, 50);
      idle(4);
      checks++;
      if (obs_val.size() != NOUT) begin
        errors++;
        $display("FAIL gaps%0d_count got %0d want %0d", rep, obs_val.size(), NOUT);
      end
      for (int j = 0; j < NOUT && j < obs_val.size(); j++) begin
        exp = model_out(j / OX, j % OX);
        checks++;
        if (obs_val[j] !== exp || obs_done[j] !== (j == NOUT-1) ||
            obs_beat[j] != br_beat(j) || obs_adj[j] !== 1'b1) begin
          errors++;
          $display("FAIL gaps%0d_out%0d got %h done=%b beat=%0d adj=%b want %h beat=%0d",
                   rep, j, obs_val[j], obs_done[j], obs_beat[j], obs_adj[j],
                   exp, br_beat(j));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    int           ndone;
    ndone = 0;
    for (int f = 0; f < 2; f++) begin
      set_ramp(f * 1000);
      clear_obs();
      run_beats(NPIX, 0);
      if (f == 1) idle(2);
      checks++;
      if (obs_val.size() != NOUT) begin
        errors++;
        $display("FAIL b2b%0d_count got %0d want %0d", f, obs_val.size(), NOUT);
      end
      for (int j = 0; j < NOUT && j < obs_val.size(); j++) begin
        exp = model_out(j / OX, j % OX);
        if (obs_done[j]) ndone++;
        checks++;
        if (obs_val[j] !== exp || obs_done[j] !== (j == NOUT-1) ||
            obs_val[j][DW-1:0] !== DW'(f*1000 + 16*(j / OX) + 2*(j % OX) + 9)) begin
          errors++;
          $display("FAIL b2b%0d_out%0d got %h done=%b want %h done=%b",
                   f, j, obs_val[j], obs_done[j], exp, (j == NOUT-1));
        end
      end
    end
    checks++;
    if (ndone != 2) begin
      errors++; $display("FAIL b2b_done_pulses got %0d want 2", ndone);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp;
    set_ramp(0);
    run_beats(20, 0);
    // Asynchronous assertion away from the clock edge.
    reset_n = 1'b0;
    #1;
    checks++;
    if (ot_valid !== 1'b0 || ot_fmap !== '0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got valid=%b fmap=%h done=%b want 0 0 0",
               ot_valid, ot_fmap, frame_done);
    end
    in_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    clear_obs();
    set_ramp(0);
    run_beats(NPIX, 0);
    idle(2);
    checks++;
    if (obs_val.size() != NOUT) begin
      errors++; $display("FAIL midrst_count got %0d want %0d", obs_val.size(), NOUT);
    end
    for (int j = 0; j < NOUT && j < obs_val.size(); j++) begin
      exp = model_out(j / OX, j % OX);
      checks++;
      if (obs_val[j] !== exp || obs_done[j] !== (j == NOUT-1) ||
          obs_beat[j] != br_beat(j)) begin
        errors++;
        $display("FAIL midrst_out%0d got %h done=%b beat=%0d want %h beat=%0d",
                 j, obs_val[j], obs_done[j], obs_beat[j], exp, br_beat(j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_channels();
    test_unsigned();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
